// File: rtl/bcd2bin.sv
// bcd2bin: sequential BCD-to-binary converter (reverse double dabble).
// One right shift per enabled clock; any BCD digit that reads >= 8 after the
// shift has 3 subtracted. After SHIFTS shifts the low bits hold the binary value.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; invalid digits are reported from here
// SHIFT | conversion in progress, one shift per enabled clock
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset (priority over en)
//   en      - clock enable; everything holds when low
//   start_i - conversion request, sampled in IDLE only
//   bcd_i   - packed BCD input, digit 0 in [3:0]
//   bin_o   - registered result, held until the next completion
//   busy_o  - conversion in progress
//   done_o  - one-enabled-cycle pulse when bin_o/err_o/ovf_o update
//   err_o   - last request contained a digit > 9
//   ovf_o   - last value did not fit in WIDTH bits (bin_o saturated)
module bcd2bin #(
  parameter int DIGITS = 5,
  parameter int WIDTH  = 16,
  parameter int SHIFTS = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start_i,
  input  logic [4*DIGITS-1:0] bcd_i,
  output logic [WIDTH-1:0]    bin_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                ovf_o
);

  localparam int CW  = $clog2(SHIFTS + 1);
  localparam int SRW = 4 * DIGITS + SHIFTS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRW-1:0]     sr_q, sr_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [SRW-1:0]     sr_adj;
  logic               bcd_bad;

  // Shift first, then correct every digit field from its post-shift value.
  always_comb begin
    sr_adj = sr_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_adj[SHIFTS + 4*i +: 4] >= 4'd8)
        sr_adj[SHIFTS + 4*i +: 4] = sr_adj[SHIFTS + 4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bin_d   = bin_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (bcd_bad) begin
              bin_d  = '0;
              err_d  = 1'b1;
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end else begin
              sr_d    = {bcd_i, {SHIFTS{1'b0}}};
              cnt_d   = '0;
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          sr_d  = sr_adj;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SHIFTS - 1)) begin
            state_d = IDLE;
            // Anything above bit WIDTH-1 means the value does not fit: saturate.
            if (sr_adj[SHIFTS-1:WIDTH] != '0) begin
              bin_d = '1;
              ovf_d = 1'b1;
            end else begin
              bin_d = sr_adj[WIDTH-1:0];
              ovf_d = 1'b0;
            end
            err_d  = 1'b0;
            done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bin_o  = bin_q;
  assign busy_o = (state_q == SHIFT);
  assign done_o = done_q;
  assign err_o  = err_q;
  assign ovf_o  = ovf_q;

endmodule
